// File: rtl/traversal_pkg.sv
// ---------------------------------------------------------------------------
// traversal_pkg
// Shared types, literal-word field positions and helpers for the BCP
// watch-list traversal engine.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package traversal_pkg;

   // Default geometry: 12-bit clause pointers, 18-bit literal words.
   localparam int TRAV_ADDR_W = 12;
   localparam int TRAV_DATA_W = TRAV_ADDR_W + 6;

   // Literal word layout: [17] END, [16] POL, [15] OASG, [14] OVAL,
   // [13:12] reserved, [11:0] NEXT.
   localparam int LIT_END      = 17;
   localparam int LIT_POL      = 16;
   localparam int LIT_OASG     = 15;
   localparam int LIT_OVAL     = 14;
   localparam int LIT_RSVD_MSB = 13;
   localparam int LIT_RSVD_LSB = 12;
   localparam int LIT_NEXT_MSB = 11;
   localparam int LIT_NEXT_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_EVAL = 2'd2,
      ST_DONE = 2'd3
   } trav_state_e;

   // Implication report: valid flag, five zero bits, clause pointer.
   function automatic logic [TRAV_DATA_W-1:0] build_report(input logic [TRAV_ADDR_W-1:0] ptr);
      return {1'b1, 5'b0, ptr};
   endfunction

endpackage

`default_nettype wire

// File: rtl/trav_node_eval.sv
// ---------------------------------------------------------------------------
// trav_node_eval
// Combinational classification of one watched-literal word against the
// value just assigned to the propagated variable.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module trav_node_eval
   import traversal_pkg::*;
(
   input  logic [TRAV_DATA_W-1:0] word_i,
   input  logic                   value_i,
   output logic                   satisfied_o,
   output logic                   unit_o,
   output logic                   conflict_o,
   output logic                   last_o,
   output logic [TRAV_ADDR_W-1:0] next_o
);

   logic       lit_true;
   logic [1:0] rsvd_unused;

   // Decode the literal word; the three clause outcomes are mutually exclusive.
   always_comb begin
      lit_true    = (value_i == word_i[LIT_POL]);
      satisfied_o = lit_true | (word_i[LIT_OASG] & word_i[LIT_OVAL]);
      unit_o      = ~lit_true & ~word_i[LIT_OASG];
      conflict_o  = ~lit_true & word_i[LIT_OASG] & ~word_i[LIT_OVAL];
      last_o      = word_i[LIT_END];
      next_o      = word_i[LIT_NEXT_MSB:LIT_NEXT_LSB];
      rsvd_unused = word_i[LIT_RSVD_MSB:LIT_RSVD_LSB];
   end

endmodule

`default_nettype wire

// File: rtl/traversal_engine.sv
// ---------------------------------------------------------------------------
// traversal_engine
// BCP watch-list traversal: walks the linked list of clauses watching the
// freshly assigned variable, reports unit clauses, flags conflicts and
// pulses FINISH when the walk ends.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module traversal_engine
   import traversal_pkg::*;
#(
   parameter int ADDR_W    = TRAV_ADDR_W,
   parameter int DATA_W    = TRAV_DATA_W,
   parameter int MAX_STEPS = 4095
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              value_i,
   input  logic [1:0]        offset_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_in_i,
   output logic [DATA_W-1:0] data_out_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              finish_o,
   output logic              conflict_o
);

   localparam int STEP_W = $clog2(MAX_STEPS + 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

   trav_state_e       state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              val_q, val_d;
   logic [1:0]        off_q, off_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              fin_q, fin_d;
   logic              conf_q, conf_d;

   // Classification of the word captured in WAIT, consumed in EVAL.
   logic              ev_conf_q, ev_conf_d;
   logic              ev_last_q, ev_last_d;
   logic [ADDR_W-1:0] ev_next_q, ev_next_d;

   logic              nd_sat_unused;
   logic              nd_unit;
   logic              nd_conf;
   logic              nd_last;
   logic [ADDR_W-1:0] nd_next;

   // The incoming read data is classified as it arrives so the unit report
   // can be registered and shown during the EVAL cycle itself.
   trav_node_eval u_node_eval (
      .word_i      (data_in_i),
      .value_i     (val_q),
      .satisfied_o (nd_sat_unused),
      .unit_o      (nd_unit),
      .conflict_o  (nd_conf),
      .last_o      (nd_last),
      .next_o      (nd_next)
   );

   // Next-state and next-output logic for the traversal FSM.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      step_d    = step_q;
      val_d     = val_q;
      off_d     = off_q;
      addr_d    = addr_q;
      dout_d    = '0;
      fin_d     = 1'b0;
      conf_d    = 1'b0;
      ev_conf_d = ev_conf_q;
      ev_last_d = ev_last_q;
      ev_next_d = ev_next_q;

      case (state_q)
         ST_IDLE: begin
            if (en_i) begin
               ptr_d   = data_in_i[ADDR_W-1:0];
               val_d   = value_i;
               off_d   = offset_i;
               step_d  = '0;
               addr_d  = {data_in_i[ADDR_W-1:2], offset_i};
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (en_i) begin
               ev_conf_d = nd_conf;
               ev_last_d = nd_last;
               ev_next_d = nd_next;
               if (nd_unit) begin
                  dout_d = build_report(ptr_q);
               end
               state_d = ST_EVAL;
            end
         end
         ST_EVAL: begin
            if (ev_conf_q) begin
               conf_d  = 1'b1;
               fin_d   = 1'b1;
               state_d = ST_DONE;
            end else if (ev_last_q || (step_q == STEP_LAST)) begin
               fin_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               ptr_d   = ev_next_q;
               step_d  = step_q + STEP_W'(1);
               addr_d  = {ev_next_q[ADDR_W-1:2], off_q};
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers, cleared immediately by reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         step_q    <= '0;
         val_q     <= 1'b0;
         off_q     <= 2'b0;
         addr_q    <= '0;
         dout_q    <= '0;
         fin_q     <= 1'b0;
         conf_q    <= 1'b0;
         ev_conf_q <= 1'b0;
         ev_last_q <= 1'b0;
         ev_next_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         step_q    <= step_d;
         val_q     <= val_d;
         off_q     <= off_d;
         addr_q    <= addr_d;
         dout_q    <= dout_d;
         fin_q     <= fin_d;
         conf_q    <= conf_d;
         ev_conf_q <= ev_conf_d;
         ev_last_q <= ev_last_d;
         ev_next_q <= ev_next_d;
      end
   end

   assign data_out_o = dout_q;
   assign addr_o     = addr_q;
   assign finish_o   = fin_q;
   assign conflict_o = conf_q;

endmodule

`default_nettype wire

// File: tb/tb_traversal_engine.sv
// ---------------------------------------------------------------------------
// tb_traversal_engine
// Self-checking bench for traversal_engine: directed scenarios plus random
// clause chains, compared against a list-walking reference model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_traversal_engine;

   localparam int MAXS = 4;

   logic        clk;
   logic        rst;
   logic        value;
   logic [1:0]  offset;
   logic        en;
   logic [17:0] din;
   logic [17:0] dout;
   logic [11:0] addr;
   logic        finish;
   logic        conflict;

   logic [17:0] mem [4096];

   int n_checks = 0;
   int n_pass   = 0;

   logic [11:0] exp_addr[$];
   logic [17:0] exp_rep[$];
   logic        exp_conf;

   traversal_engine #(
      .ADDR_W    (12),
      .DATA_W    (18),
      .MAX_STEPS (MAXS)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .value_i    (value),
      .offset_i   (offset),
      .en_i       (en),
      .data_in_i  (din),
      .data_out_o (dout),
      .addr_o     (addr),
      .finish_o   (finish),
      .conflict_o (conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference: follow the watch list through memory and record each read
   // address, the report seen for each node, and whether a conflict ends it.
   task automatic model(input logic [11:0] head, input logic v, input logic [1:0] off);
      logic [11:0] p;
      logic [11:0] a;
      logic [17:0] w;
      logic        lt;
      exp_addr.delete();
      exp_rep.delete();
      exp_conf = 1'b0;
      p = head;
      for (int s = 0; s < MAXS; s++) begin
         a = {p[11:2], off};
         exp_addr.push_back(a);
         w  = mem[a];
         lt = (w[16] == v);
         if (!lt && !w[15]) exp_rep.push_back({1'b1, 5'b0, p});
         else               exp_rep.push_back(18'h0);
         if (!lt && w[15] && !w[14]) begin
            exp_conf = 1'b1;
            break;
         end
         if (w[17]) break;
         p = w[11:0];
      end
   endtask

   task automatic run_walk(input logic [11:0] head, input logic v, input logic [1:0] off,
                           input int min_st, input int max_st);
      int nreads;
      int sz;
      int st;
      bit done;
      model(head, v, off);
      sz = exp_addr.size();
      din    = {6'($urandom), head};
      value  = v;
      offset = off;
      en     = 1'b1;
      tick();
      en     = 1'b0;
      done   = 1'b0;
      nreads = 0;
      for (int n = 0; n < 16 && !done; n++) begin
         if (n >= sz) begin
            check("extra_read", 32'(n), 32'(sz));
            break;
         end
         value  = 1'($urandom);
         offset = 2'($urandom);
         din    = 18'($urandom);
         check("addr", 32'(addr), 32'(exp_addr[n]));
         st = $urandom_range(max_st, min_st);
         for (int s = 0; s < st; s++) begin
            tick();
            check("addr_hold", 32'(addr), 32'(exp_addr[n]));
            check("stall_dout", 32'(dout), 32'h0);
         end
         en  = 1'b1;
         din = mem[addr];
         tick();
         nreads++;
         check("report", 32'(dout), 32'(exp_rep[n]));
         check("fin_early", 32'(finish), 32'h0);
         en     = 1'($urandom);
         din    = 18'($urandom);
         value  = 1'($urandom);
         offset = 2'($urandom);
         tick();
         en = 1'b0;
         check("finish", 32'(finish), 32'(n == sz - 1));
         if (finish) done = 1'b1;
      end
      check("nreads", 32'(nreads), 32'(sz));
      check("conflict", 32'(conflict), 32'(exp_conf));
      check("dout_done", 32'(dout), 32'h0);
      en  = 1'b1;
      din = 18'($urandom);
      tick();
      en = 1'b0;
      check("idle_fin", 32'(finish), 32'h0);
      check("idle_conf", 32'(conflict), 32'h0);
      tick();
      check("idle_addr", 32'(addr), 32'(exp_addr[sz-1]));
   endtask

   initial begin
      logic [11:0] head;
      logic [11:0] p;
      logic [11:0] nxt;
      logic        v;
      logic [1:0]  off;
      int          len;

      for (int i = 0; i < 4096; i++) mem[i] = 18'($urandom);
      rst = 1'b1; en = 1'b0; din = '0; value = 1'b0; offset = 2'b0;
      tick();
      tick();
      check("rst_addr", 32'(addr), 32'h0);
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_fin", 32'(finish), 32'h0);
      check("rst_conf", 32'(conflict), 32'h0);
      rst = 1'b0;
      tick();

      // Single unit clause: head 0x004, VALUE=1, OFFSET=1.
      mem[12'h005] = 18'h20000;
      run_walk(12'h004, 1'b1, 2'd1, 0, 0);

      // Satisfied chain 0x000 -> 0x008 -> 0x010 (END).
      mem[12'h001] = {1'b0, 1'b1, 2'b00, 2'b00, 12'h008};
      mem[12'h009] = {1'b0, 1'b1, 2'b00, 2'b00, 12'h010};
      mem[12'h011] = {1'b1, 1'b1, 2'b00, 2'b00, 12'h000};
      run_walk(12'h000, 1'b1, 2'd1, 0, 0);

      // Conflict on the second node; its NEXT must not be followed.
      mem[12'h000] = {1'b0, 1'b0, 2'b00, 2'b00, 12'h040};
      mem[12'h040] = {1'b0, 1'b1, 2'b10, 2'b00, 12'h080};
      mem[12'h080] = {1'b1, 1'b0, 2'b00, 2'b00, 12'h000};
      run_walk(12'h000, 1'b0, 2'd0, 0, 0);

      // Memory stall of five cycles per node.
      run_walk(12'h000, 1'b1, 2'd1, 5, 5);

      // Self-loop, never END: bounded by the step limit.
      mem[12'h022] = {1'b0, 1'b1, 2'b00, 2'b00, 12'h020};
      run_walk(12'h020, 1'b1, 2'd2, 0, 1);

      // Reset while waiting on memory.
      din = {6'h0, 12'h100}; value = 1'b1; offset = 2'd3; en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      tick();
      check("pre_rst_addr", 32'(addr), 32'h103);
      rst = 1'b1;
      #1;
      check("mid_rst_addr", 32'(addr), 32'h0);
      check("mid_rst_dout", 32'(dout), 32'h0);
      check("mid_rst_fin", 32'(finish), 32'h0);
      check("mid_rst_conf", 32'(conflict), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_fin", 32'(finish), 32'h0);
      end

      // Random chains.
      for (int it = 0; it < 40; it++) begin
         head = 12'($urandom);
         v    = 1'($urandom);
         off  = 2'($urandom);
         len  = $urandom_range(6, 1);
         p    = head;
         for (int k = 0; k < len; k++) begin
            nxt = 12'($urandom);
            mem[{p[11:2], off}] = {(k == len - 1), 1'($urandom), 1'($urandom),
                                   1'($urandom), 2'($urandom), nxt};
            p = nxt;
         end
         run_walk(head, v, off, 0, 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
